chunk_unpacker: RTL

Downstream consumer of the memory control unit's wide chunk port. It accepts `num_bits`-wide chunks and buffers them in a two-slot ping-pong store. It streams each chunk out as fixed-width beats of `lanes` packed elements over a valid/ready handshake, feeding the compute array's operand input. Chunk acceptance into one slot overlaps with draining of the other, so sustained throughput is one beat per cycle.

---
 rtl/chunk_unpacker_if.sv | 30 +++
 rtl/chunk_unpacker.sv | 72 +++++++
 2 files changed

// File: rtl/chunk_unpacker_if.sv
// Chunk-in / beat-out handshake bundle for chunk_unpacker.
// slave is the unpacker side; master is the producer/consumer environment.
interface chunk_unpacker_if #(
  parameter int num_bits  = 512,
  parameter int elem_bits = 8,
  parameter int lanes     = 4
);
  localparam int BW = lanes * elem_bits;
  localparam int NB = num_bits / BW;
  localparam int IW = $clog2(NB);

  logic [num_bits-1:0] chunk_in;
  logic                chunk_valid;
  logic                chunk_ready;
  logic [BW-1:0]       beat_out;
  logic                beat_valid;
  logic                beat_ready;
  logic                beat_last;
  logic [IW-1:0]       beat_idx;

  modport slave (
    input  chunk_in, chunk_valid, beat_ready,
    output chunk_ready, beat_out, beat_valid, beat_last, beat_idx
  );

  modport master (
    output chunk_in, chunk_valid, beat_ready,
    input  chunk_ready, beat_out, beat_valid, beat_last, beat_idx
  );
endinterface

// File: rtl/chunk_unpacker.sv
// Two-slot ping-pong buffer that streams wide chunks out as lanes-wide beats,
// least-significant beat first; fill of one slot overlaps drain of the other.
module chunk_unpacker #(
  parameter int num_bits  = 512,
  parameter int elem_bits = 8,
  parameter int lanes     = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  chunk_unpacker_if.slave     bus,
  output logic [15:0]         chunk_count
);
  localparam int BW = lanes * elem_bits;
  localparam int NB = num_bits / BW;
  localparam int IW = $clog2(NB);

  logic [num_bits-1:0] slot [2];
  logic [1:0]          full;
  logic                wr_ptr;
  logic                rd_ptr;
  logic [IW-1:0]       beat_cnt;
  logic                accept;
  logic                drain;
  logic                last;

  // Accept needs the write slot empty and drain needs the read slot full, so
  // the two never touch the same slot in one cycle.
  always_comb begin
    accept = bus.chunk_valid && !full[wr_ptr];
    drain  = full[rd_ptr] && bus.beat_ready;
    last   = (beat_cnt == IW'(NB - 1));
  end

  assign bus.chunk_ready = !full[wr_ptr];
  assign bus.beat_valid  = full[rd_ptr];
  assign bus.beat_out    = slot[rd_ptr][beat_cnt*BW +: BW];
  assign bus.beat_idx    = beat_cnt;
  assign bus.beat_last   = last;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 2; i++) slot[i] <= '0;
      full        <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      beat_cnt    <= '0;
      chunk_count <= '0;
    end else if (flush) begin
      full     <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      beat_cnt <= '0;
    end else begin
      if (accept) begin
        slot[wr_ptr] <= bus.chunk_in;
        full[wr_ptr] <= 1'b1;
        wr_ptr       <= ~wr_ptr;
      end
      if (drain) begin
        if (last) begin
          beat_cnt     <= '0;
          full[rd_ptr] <= 1'b0;
          rd_ptr       <= ~rd_ptr;
          chunk_count  <= chunk_count + 16'd1;
        end else begin
          beat_cnt <= beat_cnt + IW'(1);
        end
      end
    end
  end
endmodule
